addsub_sequencer: RTL and testbench

- Command-level controller sitting directly upstream of the registered n-bit adder/subtractor datapath (registered A/B/Sel/AddSub inputs, registered Z/Overflow outputs, Z fed back through the operand mux).
- Accepts operation commands over a valid/ready handshake and drives the datapath's A, B, Sel and AddSub inputs.
- Supports repeated accumulate operations, e.g. multiply-by-repeated-addition.
- Samples the datapath's Z and Overflow at the correct pipeline depth and returns one result per command.

---
 rtl/addsub_sequencer.sv | 103 ++++++++++
 tb/tb_addsub_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: command-level controller for the registered add/sub datapath.
// Issues one iteration per cycle, drives NOP when idle, and samples Z/Overflow three edges after issue.
module addsub_sequencer #(
    parameter int n = 16,
    parameter int C = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    input  logic [C-1:0] cmd_cnt,
    output logic [n-1:0] A,
    output logic [n-1:0] B,
    output logic         Sel,
    output logic         AddSub,
    input  logic [n-1:0] Z,
    input  logic         Overflow,
    output logic         res_valid,
    output logic [n-1:0] res_data,
    output logic         res_ovf
);
    typedef enum logic {IDLE, REPEAT} state_t;

    state_t       state;
    logic [n-1:0] b_l;
    logic         sub_l;
    logic [C-1:0] rem;
    logic [2:0]   pv, pf, pl;
    logic         ovf_acc;
    logic         accept, multi, ovf_now;

    assign accept  = state == IDLE && cmd_ready && cmd_valid;
    assign multi   = cmd_op[1] && cmd_cnt != '0;
    assign ovf_now = pf[2] ? Overflow : ovf_acc | Overflow;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            A         <= '0;
            B         <= '0;
            Sel       <= 1'b1;
            AddSub    <= 1'b0;
            b_l       <= '0;
            sub_l     <= 1'b0;
            rem       <= '0;
            pv        <= '0;
            pf        <= '0;
            pl        <= '0;
            ovf_acc   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
        end else begin
            // default is a NOP issue (Z = Z + 0) so the enable-less datapath holds Z
            A      <= '0;
            B      <= '0;
            Sel    <= 1'b1;
            AddSub <= 1'b0;
            pv     <= {pv[1:0], 1'b0};
            pf     <= {pf[1:0], 1'b0};
            pl     <= {pl[1:0], 1'b0};
            if (state == REPEAT) begin
                B      <= b_l;
                AddSub <= sub_l;
                pv     <= {pv[1:0], 1'b1};
                pl     <= {pl[1:0], rem == C'(1)};
                rem    <= rem - C'(1);
                if (rem == C'(1)) begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            end else if (accept) begin
                A      <= cmd_op[1] ? '0 : cmd_a;
                B      <= cmd_b;
                Sel    <= cmd_op[1];
                AddSub <= cmd_op[0];
                pv     <= {pv[1:0], 1'b1};
                pf     <= {pf[1:0], 1'b1};
                pl     <= {pl[1:0], !multi};
                cmd_ready <= !multi;
                if (multi) begin
                    state <= REPEAT;
                    b_l   <= cmd_b;
                    sub_l <= cmd_op[0];
                    rem   <= cmd_cnt;
                end
            end else begin
                cmd_ready <= 1'b1;
            end
            res_valid <= pv[2] && pl[2];
            if (pv[2])
                ovf_acc <= ovf_now;
            if (pv[2] && pl[2]) begin
                res_data <= Z;
                res_ovf  <= ovf_now;
            end
        end
    end
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: drives commands into the sequencer wired to a behavioural
// registered add/sub datapath; results are checked against a scoreboard queue.
module tb_addsub_sequencer;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_cnt = '0;
    logic [15:0] A, B, Z;
    logic        Sel, AddSub, Overflow;
    logic        res_valid, res_ovf;
    logic [15:0] res_data;

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, n_res = 0, cyc = 0;
    logic [15:0] mz = '0;

    addsub_sequencer #(.n(16), .C(4)) dut (
        .Clock(Clock), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
        .A(A), .B(B), .Sel(Sel), .AddSub(AddSub), .Z(Z), .Overflow(Overflow),
        .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [16:0] calc(input logic [15:0] x, input logic [15:0] y, input logic sub);
        logic [15:0] s;
        logic        o;
        s = sub ? x - y : x + y;
        o = sub ? (x[15] != y[15]) && (s[15] != x[15]) : (x[15] == y[15]) && (s[15] != x[15]);
        return {o, s};
    endfunction

    // datapath: registered inputs, registered Z/Overflow, Z fed back through the A/Z mux
    logic [15:0] ra, rb;
    logic        rs, rsub;
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ra <= '0; rb <= '0; rs <= 1'b0; rsub <= 1'b0; Z <= '0; Overflow <= 1'b0;
        end else begin
            ra <= A; rb <= B; rs <= Sel; rsub <= AddSub;
            {Overflow, Z} <= calc(rs ? Z : ra, rb, rsub);
        end
    end

    always @(negedge Clock) begin
        if (Resetn && res_valid) begin
            exp_t e;
            n_res++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: res_valid=1 data=%h, required no result", res_data);
            end else begin
                e = sb.pop_front();
                if (res_data !== e.d) begin
                    n_bad++;
                    $display("FAIL res_data: got %h, required %h", res_data, e.d);
                end
                n_cmp++;
                if (res_ovf !== e.o) begin
                    n_bad++;
                    $display("FAIL res_ovf: got %b, required %b (data %h)", res_ovf, e.o, e.d);
                end
                n_cmp++;
                if (cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL latency: result at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] cnt);
        exp_t        e;
        logic [16:0] r;
        logic        o;
        int          k, w;
        @(negedge Clock);
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge Clock);
            w++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b, required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cnt = cnt;
        @(posedge Clock);
        #1 cmd_valid = 1'b0;
        k = op[1] ? int'(cnt) : 0;
        o = 1'b0;
        for (int i = 0; i <= k; i++) begin
            r = calc(op[1] ? mz : a, b, op[0]);
            mz = r[15:0];
            o = o | r[16];
        end
        e.d = mz; e.o = o; e.cyc = cyc + 3 + k;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge Clock);
            w++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic ready_low(output int w);
        w = 0;
        @(negedge Clock);
        while (!cmd_ready && w < 40) begin
            w++;
            @(negedge Clock);
        end
    endtask

    task automatic check_nop(input string name, input logic rdy);
        n_cmp++;
        if ({cmd_ready, A, B, Sel, AddSub, res_valid, res_data, res_ovf} !==
            {rdy, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: rdy=%b A=%h B=%h Sel=%b AddSub=%b rv=%b rd=%h ro=%b, required rdy=%b A=0 B=0 Sel=1 AddSub=0 rv=0 rd=0 ro=0",
                     name, cmd_ready, A, B, Sel, AddSub, res_valid, res_data, res_ovf, rdy);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        check_nop("reset_values", 1'b0);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        check_nop("after_release", 1'b1);
    endtask

    task automatic test_load();
        send(2'b00, 16'd5, 16'd3, 4'd9);
        wait_drain();
        @(negedge Clock);
        n_cmp++;
        if ({A, B, Sel} !== {16'h0, 16'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL nop_after_load: A=%h B=%h Sel=%b, required 0 0 1", A, B, Sel);
        end
        send(2'b01, 16'h8000, 16'h0001, 4'd0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        send(2'b00, 16'd10, 16'd0, 4'd0);
        send(2'b11, 16'hFFFF, 16'd4, 4'd0);
        wait_drain();
    endtask

    task automatic test_repeat();
        int w;
        send(2'b00, 16'd0, 16'd0, 4'd0);
        send(2'b10, 16'hAAAA, 16'd7, 4'd4);
        ready_low(w);
        n_cmp++;
        if (w !== 4) begin
            n_bad++;
            $display("FAIL ready_low_cnt4: low for %0d cycles, required 4", w);
        end
        wait_drain();
        send(2'b00, 16'd100, 16'd0, 4'd0);
        send(2'b11, 16'd0, 16'd2, 4'd15);
        ready_low(w);
        n_cmp++;
        if (w !== 15) begin
            n_bad++;
            $display("FAIL ready_low_cnt15: low for %0d cycles, required 15", w);
        end
        wait_drain();
    endtask

    task automatic test_wrap();
        send(2'b00, 16'h7FF0, 16'd0, 4'd0);
        send(2'b10, 16'd0, 16'h0010, 4'd1);
        wait_drain();
    endtask

    task automatic test_idle_hold();
        int seen;
        send(2'b00, 16'h1234, 16'd0, 4'd0);
        wait_drain();
        seen = n_res;
        repeat (20) @(negedge Clock);
        n_cmp++;
        if (n_res !== seen) begin
            n_bad++;
            $display("FAIL idle_strobe: %0d results while idle, required 0", n_res - seen);
        end
        send(2'b10, 16'd0, 16'd1, 4'd0);
        wait_drain();
    endtask

    task automatic test_reset_mid_repeat();
        int seen;
        send(2'b10, 16'd0, 16'd1, 4'd10);
        repeat (3) @(negedge Clock);
        Resetn = 1'b0;
        #1 check_nop("mid_repeat_reset", 1'b0);
        sb.delete();
        mz = '0;
        seen = n_res;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        check_nop("after_mid_reset", 1'b1);
        repeat (20) @(negedge Clock);
        n_cmp++;
        if (n_res !== seen) begin
            n_bad++;
            $display("FAIL flushed_result: %0d results after reset, required 0", n_res - seen);
        end
        send(2'b00, 16'd3, 16'd4, 4'd0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_repeat();
        test_wrap();
        test_idle_hold();
        test_reset_mid_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
